// File: rtl/shot_resolver.sv
// -----------------------------------------------------------------------------
// shot_resolver
//   Stores the player and pc 8x8 battleship grids and resolves shots against
//   them. It keeps a live count of unhit ship cells for each grid so the game
//   FSM can detect victory or defeat. A registered read port lets the VGA stage
//   colour individual cells.
//
//   Cell encoding: 00 EMPTY, 01 SHIP, 10 HIT, 11 MISS
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   clear               synchronous wipe of both grids and counters; aborts
//                       any shot in flight
//   place_*             place one ship cell (idle only, fire has priority)
//   fire_*              single-cycle shot request at board/row/column
//   busy                shot in progress; fire_req and place_valid ignored
//   fire_done           one-cycle result pulse, qualifies fire_hit/fire_repeat
//   player_ships        unhit ship cells on the player grid (saturating)
//   pc_ships            unhit ship cells on the pc grid (saturating)
//   rd_board/i/j        VGA read address
//   rd_cell             cell state, one cycle after the address is sampled
// -----------------------------------------------------------------------------
module shot_resolver #(
  parameter int GRID_W = 3,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              place_valid,
  input  logic              place_board,
  input  logic [GRID_W-1:0] place_i,
  input  logic [GRID_W-1:0] place_j,
  input  logic              fire_req,
  input  logic              fire_board,
  input  logic [GRID_W-1:0] fire_i,
  input  logic [GRID_W-1:0] fire_j,
  output logic              busy,
  output logic              fire_done,
  output logic              fire_hit,
  output logic              fire_repeat,
  output logic [CNT_W-1:0]  player_ships,
  output logic [CNT_W-1:0]  pc_ships,
  input  logic              rd_board,
  input  logic [GRID_W-1:0] rd_i,
  input  logic [GRID_W-1:0] rd_j,
  output logic [1:0]        rd_cell
);

  localparam int IDX_W = 2 * GRID_W;
  localparam int NCELL = 1 << IDX_W;

  localparam logic [1:0] C_EMPTY = 2'b00;
  localparam logic [1:0] C_SHIP  = 2'b01;
  localparam logic [1:0] C_HIT   = 2'b10;
  localparam logic [1:0] C_MISS  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITE,
    S_RESP
  } state_t;

  state_t            r_state;
  logic [1:0]        r_grid [0:1][0:NCELL-1];
  logic [CNT_W-1:0]  r_cnt  [0:1];
  logic              r_tgt_board;
  logic [IDX_W-1:0]  r_tgt_idx;
  logic [1:0]        r_cell_hold;
  logic              r_hit_pend;
  logic              r_rep_pend;
  logic              r_busy;
  logic              r_fire_done;
  logic              r_fire_hit;
  logic              r_fire_repeat;
  logic [1:0]        r_rd_cell;

  logic [IDX_W-1:0]  w_place_idx;
  logic [IDX_W-1:0]  w_fire_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  assign w_place_idx = {place_i, place_j};
  assign w_fire_idx  = {fire_i, fire_j};
  assign w_rd_idx    = {rd_i, rd_j};

  assign busy         = r_busy;
  assign fire_done    = r_fire_done;
  assign fire_hit     = r_fire_hit;
  assign fire_repeat  = r_fire_repeat;
  assign player_ships = r_cnt[0];
  assign pc_ships     = r_cnt[1];
  assign rd_cell      = r_rd_cell;

  // Grid, counters and shot FSM share one process so the placement path and
  // the WRITE path never drive the grid from two places.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tgt_board   <= 1'b0;
      r_tgt_idx     <= '0;
      r_cell_hold   <= C_EMPTY;
      r_hit_pend    <= 1'b0;
      r_rep_pend    <= 1'b0;
      r_busy        <= 1'b0;
      r_fire_done   <= 1'b0;
      r_fire_hit    <= 1'b0;
      r_fire_repeat <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        r_cnt[b] <= CNT_ZERO;
        for (int c = 0; c < NCELL; c++) r_grid[b][c] <= C_EMPTY;
      end
    end else if (clear) begin
      r_state       <= S_IDLE;
      r_hit_pend    <= 1'b0;
      r_rep_pend    <= 1'b0;
      r_busy        <= 1'b0;
      r_fire_done   <= 1'b0;
      r_fire_hit    <= 1'b0;
      r_fire_repeat <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        r_cnt[b] <= CNT_ZERO;
        for (int c = 0; c < NCELL; c++) r_grid[b][c] <= C_EMPTY;
      end
    end else begin
      r_fire_done   <= 1'b0;
      r_fire_hit    <= 1'b0;
      r_fire_repeat <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fire_req) begin
            r_tgt_board <= fire_board;
            r_tgt_idx   <= w_fire_idx;
            r_busy      <= 1'b1;
            r_state     <= S_LOOKUP;
          end else if (place_valid &&
                       r_grid[place_board][w_place_idx] == C_EMPTY) begin
            // Cell becomes SHIP even when the counter is already saturated.
            r_grid[place_board][w_place_idx] <= C_SHIP;
            if (r_cnt[place_board] != CNT_MAX)
              r_cnt[place_board] <= r_cnt[place_board] + CNT_ONE;
          end
        end
        S_LOOKUP: begin
          r_cell_hold <= r_grid[r_tgt_board][r_tgt_idx];
          r_state     <= S_WRITE;
        end
        S_WRITE: begin
          r_hit_pend <= 1'b0;
          r_rep_pend <= 1'b0;
          case (r_cell_hold)
            C_SHIP: begin
              r_grid[r_tgt_board][r_tgt_idx] <= C_HIT;
              r_hit_pend <= 1'b1;
              // A saturated counter can under-count, so hold at zero.
              if (r_cnt[r_tgt_board] != CNT_ZERO)
                r_cnt[r_tgt_board] <= r_cnt[r_tgt_board] - CNT_ONE;
            end
            C_EMPTY: r_grid[r_tgt_board][r_tgt_idx] <= C_MISS;
            default: r_rep_pend <= 1'b1;
          endcase
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_fire_done   <= 1'b1;
          r_fire_hit    <= r_hit_pend;
          r_fire_repeat <= r_rep_pend;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Non-blocking read of the array gives read-before-write against the
  // WRITE-state update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd_cell <= C_EMPTY;
    else     r_rd_cell <= r_grid[rd_board][w_rd_idx];
  end

endmodule

// File: tb/tb_shot_resolver.sv
module tb_shot_resolver;

  logic       clk = 1'b0;
  logic       rst, clear;
  logic       place_valid, place_board;
  logic [2:0] place_i, place_j;
  logic       fire_req, fire_board;
  logic [2:0] fire_i, fire_j;
  logic       busy, fire_done, fire_hit, fire_repeat;
  logic [2:0] player_ships, pc_ships;
  logic       rd_board;
  logic [2:0] rd_i, rd_j;
  logic [1:0] rd_cell;

  shot_resolver #(.GRID_W(3), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .place_valid(place_valid), .place_board(place_board),
    .place_i(place_i), .place_j(place_j),
    .fire_req(fire_req), .fire_board(fire_board),
    .fire_i(fire_i), .fire_j(fire_j),
    .busy(busy), .fire_done(fire_done), .fire_hit(fire_hit),
    .fire_repeat(fire_repeat),
    .player_ships(player_ships), .pc_ships(pc_ships),
    .rd_board(rd_board), .rd_i(rd_i), .rd_j(rd_j), .rd_cell(rd_cell)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: cell values 0 EMPTY, 1 SHIP, 2 HIT, 3 MISS
  int m_grid [2][8][8];
  int m_cnt  [2];
  localparam int M_MAX = 7;

  function automatic void m_wipe();
    for (int b = 0; b < 2; b++) begin
      m_cnt[b] = 0;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) m_grid[b][i][j] = 0;
    end
  endfunction

  function automatic void m_place(input int b, input int i, input int j);
    if (m_grid[b][i][j] == 0) begin
      m_grid[b][i][j] = 1;
      if (m_cnt[b] < M_MAX) m_cnt[b]++;
    end
  endfunction

  function automatic void m_fire(input int b, input int i, input int j,
                                 output bit hit, output bit rep);
    hit = 0; rep = 0;
    if (m_grid[b][i][j] == 1) begin
      hit = 1; m_grid[b][i][j] = 2;
      if (m_cnt[b] > 0) m_cnt[b]--;
    end else if (m_grid[b][i][j] == 0) m_grid[b][i][j] = 3;
    else rep = 1;
  endfunction

  typedef struct {
    bit hit;
    bit rep;
    int pl;
    int pc;
    int done_cyc;
  } exp_t;
  exp_t sbq[$];

  // Monitor: pops an expectation on every fire_done
  always @(negedge clk) begin
    if (fire_done) begin
      if (sbq.size() == 0) check("unexpected_fire_done", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        check("fire_hit", fire_hit, e.hit);
        check("fire_repeat", fire_repeat, e.rep);
        check("done_player_ships", player_ships, e.pl);
        check("done_pc_ships", pc_ships, e.pc);
        check("done_latency_cycle", cyc, e.done_cyc);
      end
    end else if (fire_hit || fire_repeat) begin
      check("flags_without_done", {fire_hit, fire_repeat}, 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_place(input int b, input int i, input int j);
    place_valid = 1; place_board = b[0]; place_i = i[2:0]; place_j = j[2:0];
    tick();
    place_valid = 0;
    m_place(b, i, j);
  endtask

  // Drives a one-cycle shot; expected done is 4 negedges after driving.
  task automatic do_fire(input int b, input int i, input int j, input bit expect_done);
    bit   hit, rep;
    exp_t e;
    if (expect_done) begin
      m_fire(b, i, j, hit, rep);
      e.hit = hit; e.rep = rep; e.pl = m_cnt[0]; e.pc = m_cnt[1];
      e.done_cyc = cyc + 4;
      sbq.push_back(e);
    end
    fire_req = 1; fire_board = b[0]; fire_i = i[2:0]; fire_j = j[2:0];
    tick();
    fire_req = 0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
    if (sbq.size() != 0) begin
      check("fire_done_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  task automatic check_rd(input string name, input int b, input int i, input int j);
    rd_board = b[0]; rd_i = i[2:0]; rd_j = j[2:0];
    tick();
    check(name, rd_cell, m_grid[b][i][j]);
  endtask

  task automatic check_wiped(input string tag);
    check({tag, "_player_ships"}, player_ships, 0);
    check({tag, "_pc_ships"}, pc_ships, 0);
    check({tag, "_busy"}, busy, 0);
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) check_rd({tag, "_rd_cell"}, b, i, j);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int pre;
    rst = 1; clear = 0; place_valid = 0; place_board = 0; place_i = 0; place_j = 0;
    fire_req = 0; fire_board = 0; fire_i = 0; fire_j = 0;
    rd_board = 0; rd_i = 0; rd_j = 0;
    m_wipe();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_fire_done", fire_done, 0);
    check("rst_player_ships", player_ships, 0);
    check("rst_pc_ships", pc_ships, 0);
    check("rst_rd_cell", rd_cell, 0);
    rst = 0;
    tick();

    // Placement on pc grid
    do_place(1, 1, 2);
    do_place(1, 1, 3);
    check("place_pc_ships", pc_ships, m_cnt[1]);
    check_rd("place_rd_cell", 1, 1, 2);

    // Hit with read-before-write on the target cell
    pre = m_grid[1][1][2];
    do_fire(1, 1, 2, 1);
    rd_board = 1; rd_i = 1; rd_j = 2;
    tick();
    tick();
    check("rd_before_write", rd_cell, pre);
    tick();
    check("rd_after_write", rd_cell, m_grid[1][1][2]);
    wait_idle();
    do_fire(1, 1, 2, 1);
    wait_idle();
    check("repeat_pc_ships", pc_ships, m_cnt[1]);

    // Miss on empty player cell
    do_fire(0, 7, 7, 1);
    wait_idle();
    check_rd("miss_rd_cell", 0, 7, 7);

    // fire_req held across 5 edges: accepted on the 1st and 5th only
    begin
      bit   hit, rep;
      exp_t e;
      m_fire(0, 0, 0, hit, rep);
      e.hit = hit; e.rep = rep; e.pl = m_cnt[0]; e.pc = m_cnt[1]; e.done_cyc = cyc + 4;
      sbq.push_back(e);
      m_fire(0, 0, 0, hit, rep);
      e.hit = hit; e.rep = rep; e.pl = m_cnt[0]; e.pc = m_cnt[1]; e.done_cyc = cyc + 8;
      sbq.push_back(e);
      fire_req = 1; fire_board = 0; fire_i = 0; fire_j = 0;
      repeat (5) tick();
      fire_req = 0;
      wait_idle();
      repeat (6) tick();
    end

    // Saturation
    clear = 1; tick(); clear = 0; m_wipe();
    for (int j = 0; j < 8; j++) do_place(0, 2, j);
    check("sat_player_ships", player_ships, m_cnt[0]);
    do_place(0, 2, 0);
    check("replace_player_ships", player_ships, m_cnt[0]);
    do_fire(0, 2, 5, 1);
    wait_idle();

    // clear while the shot is in LOOKUP
    do_place(1, 4, 4);
    do_fire(1, 4, 4, 0);
    clear = 1; tick(); clear = 0; m_wipe();
    repeat (8) tick();
    check_wiped("clear");

    // async reset mid-shot
    do_place(0, 3, 3);
    do_place(1, 5, 5);
    do_fire(0, 3, 3, 0);
    tick();
    #2 rst = 1;
    #10 rst = 0;
    m_wipe();
    repeat (8) tick();
    check_wiped("rst");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int op, b, i, j;
      op = $urandom_range(0, 9);
      b  = $urandom_range(0, 1);
      i  = $urandom_range(0, 7);
      j  = $urandom_range(0, 3);
      if (op < 4) do_place(b, i, j);
      else if (op < 7) begin
        if ($urandom_range(0, 1) == 1) begin
          // simultaneous place is dropped because fire wins
          place_valid = 1; place_board = $urandom_range(0, 1);
          place_i = $urandom_range(0, 7); place_j = $urandom_range(0, 3);
        end
        do_fire(b, i, j, 1);
        // junk requests while busy must be ignored
        for (int k = 0; k < 3; k++) begin
          place_valid = $urandom_range(0, 1); place_board = $urandom_range(0, 1);
          place_i = $urandom_range(0, 7); place_j = $urandom_range(0, 3);
          fire_req = $urandom_range(0, 1); fire_board = $urandom_range(0, 1);
          fire_i = $urandom_range(0, 7); fire_j = $urandom_range(0, 3);
          tick();
        end
        place_valid = 0; fire_req = 0;
        wait_idle();
      end else begin
        check_rd("rand_rd_cell", b, i, j);
        check("rand_player_ships", player_ships, m_cnt[0]);
        check("rand_pc_ships", pc_ships, m_cnt[1]);
      end
    end

    wait_idle();
    repeat (6) tick();
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
